// File: rtl/arb_mux.sv
// N-channel arbiter feeding a single registered output slot.
// Round-robin or fixed-priority grant; full throughput when downstream is always ready.
module arb_mux #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int RR    = 1,
  localparam int SW   = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SW-1:0]      out_sel
);

  logic [SW-1:0]    ptr_q, ptr_d;
  logic [SW-1:0]    out_sel_q, out_sel_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;

  logic [N-1:0]     grant;
  logic [SW-1:0]    winner;
  logic             found;
  logic             load_en;
  logic             in_xfer;
  int               base;
  int               idx;

  // Search upward from the base index, wrapping mod N so a non-power-of-two N never yields an index >= N.
  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    base   = (RR != 0) ? int'(ptr_q) : 0;
    for (int k = 0; k < N; k++) begin
      idx = base + k;
      if (idx >= N) idx = idx - N;
      if (!found && in_valid[idx]) begin
        found  = 1'b1;
        winner = SW'(idx);
      end
    end
    if (found) grant[winner] = 1'b1;
  end

  assign load_en  = ~out_valid_q | out_ready;
  assign in_xfer  = found & load_en & ~reset;
  assign in_ready = grant & {N{load_en & ~reset}};

  always_comb begin
    ptr_d       = ptr_q;
    out_sel_d   = out_sel_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (in_xfer) begin
      ptr_d       = (winner == SW'(N - 1)) ? '0 : winner + SW'(1);
      out_sel_d   = winner;
      out_data_d  = in_data[int'(winner)*WIDTH +: WIDTH];
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q       <= '0;
      out_sel_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      out_sel_q   <= out_sel_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_sel   = out_sel_q;

endmodule

// File: doc/arb_mux.md
ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 Parameter WIDTH, default 32, data width of every channel (WIDTH >= 1).
REQ-002 Parameter N, default 4, number of input channels (N >= 2).
REQ-003 Parameter RR, default 1: 1 = round-robin arbitration, 0 = fixed priority with channel 0 highest.
REQ-004 Localparam SW = $clog2(N), width of the select index.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in_data  input  N*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 in_valid  input  N  per-channel request.
REQ-009 in_ready  output  N  per-channel accept, one-hot or zero.
REQ-010 out_data  output  WIDTH  registered selected data.
REQ-011 out_valid  output  1  out_data holds an untaken word.
REQ-012 out_ready  input  1  downstream accept.
REQ-013 out_sel  output  SW  registered index of the channel that supplied out_data.

Function
REQ-014 Input transfer on channel i SHALL occur in a cycle with in_valid[i] and in_ready[i] both high; output transfer SHALL occur in a cycle with out_valid and out_ready both high.
REQ-015 Output stage SHALL be a single register; load_en = ~out_valid | out_ready.
REQ-016 in_ready[i] SHALL be grant[i] & load_en, combinational; in_ready SHALL be all-zero when no in_valid is high.
REQ-017 grant SHALL be one-hot over the requesting channels, or zero when none request; it SHALL never select a channel whose in_valid is low.
REQ-018 RR=0: grant SHALL select the lowest-index requesting channel.
REQ-019 RR=1: grant SHALL select the first requesting channel at or after ptr, searching upward and wrapping from N-1 to 0.
REQ-020 ptr (SW bits) SHALL update to (winner+1) mod N only on an input transfer, and SHALL hold otherwise, including while stalled on out_ready.
REQ-021 On an input transfer: out_data <= in_data of the winner; out_sel <= winner index; out_valid <= 1. Latency from input transfer to out_valid is 1 cycle.
REQ-022 Output transfer with no input transfer in the same cycle: out_valid <= 0; out_data and out_sel hold.
REQ-023 Output transfer and input transfer in the same cycle: the new word SHALL replace the old one, out_valid stays 1, and there is no bubble (full throughput, 1 word/cycle).
REQ-024 Stall (out_valid=1, out_ready=0): out_data, out_sel, out_valid and ptr SHALL hold, and in_ready SHALL be all-zero.
REQ-025 in_valid dropping while not granted SHALL have no effect on state; no word SHALL be lost or duplicated.
REQ-026 When N is not a power of two, ptr and the winner index SHALL stay in 0..N-1, and wrap arithmetic SHALL use mod N, not mod 2^SW.
REQ-027 The output stage SHALL depend only on the chosen channel's data; out_data SHALL never be formed by OR-ing several channels.

Reset
REQ-028 While reset is high at a clock edge: out_valid <= 0, out_data <= 0, out_sel <= 0, ptr <= 0.
REQ-029 While reset is high, in_ready SHALL be all-zero regardless of the inputs.
REQ-030 Reset asserted mid-stream SHALL discard the held output word; the first grant after reset SHALL start from ptr = 0.

Verification
REQ-031 Reset, then single request: N=4, RR=1, in_valid=0001, data0=0xA5A5A5A5, out_ready=1 -> one cycle later out_valid=1, out_data=0xA5A5A5A5, out_sel=0.
REQ-032 Round-robin fairness: N=4, RR=1, in_valid=1111 held, out_ready=1 -> out_sel sequence 0,1,2,3,0,1 on consecutive cycles, with no idle cycles.
REQ-033 Fixed priority: RR=0, in_valid=0110 held, out_ready=1 -> out_sel stays 1 on every cycle; in_ready[2] is never asserted.
REQ-034 Backpressure: word held with out_ready=0 for 3 cycles and in_valid=1111 -> in_ready=0000 and out_data, out_sel, ptr unchanged; out_ready=1 -> the next channel is taken the same cycle and appears the following cycle.
REQ-035 Wrap with N=3: RR=1, in_valid=101 held -> out_sel sequence 0,2,0,2; ptr never reaches 3.
REQ-036 Mid-stream reset: out_valid=1 with out_sel=2, reset pulsed for 1 cycle -> out_valid=0, out_data=0; next grant with in_valid=1111 -> out_sel=0.
